// File: rtl/axi8_lite_master.sv
// Single-outstanding AXI4-Lite 8-bit master: command/response front end to AW/W/B and AR/R.
// Optional slave-wait timeout enabled by defining AXI8M_TIMEOUT_EN.
module axi8_lite_master #(
  parameter int unsigned ADDR_WIDTH     = 1,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP
);

  generate
    if (DATA_WIDTH != 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("axi8_lite_master: DATA_WIDTH must be 8 and TIMEOUT_CYCLES nonzero");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  state_t                state_q, state_d;
  logic                  cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                  rsp_valid_d;
  logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rsp_rdata_d;
  logic [1:0]            rsp_resp_d;
  logic                  tmo_hit;
  logic                  aw_fire, w_fire;

  assign WSTRB   = 1'b1;
  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;

`ifdef AXI8M_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // >= so a partial AW/W handshake on the expiry cycle still leaves a live timeout
  assign tmo_hit = (tmo_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      tmo_cnt_q <= '0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= '0;
    end else if (state_q inside {WR_AW_W, WR_B, RD_AR, RD_R}) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and next-output decode; every output is held in a register below
  always_comb begin
    state_d     = state_q;
    awvalid_d   = AWVALID;
    wvalid_d    = WVALID;
    bready_d    = BREADY;
    arvalid_d   = ARVALID;
    rready_d    = RREADY;
    rsp_valid_d = rsp_valid;
    awaddr_d    = AWADDR;
    araddr_d    = ARADDR;
    wdata_d     = WDATA;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end
      WR_AW_W: begin
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end else if (tmo_hit && !aw_fire && !w_fire) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      WR_B: begin
        if (BVALID && BREADY) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end else if (tmo_hit) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (ARVALID && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end else if (tmo_hit) begin
          arvalid_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD_R: begin
        if (RVALID && RREADY) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = RRESP;
          rsp_rdata_d = RDATA;
          state_d     = RSP;
        end else if (tmo_hit) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready only once IDLE is actually registered, so no accept on the response-handshake cycle
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      AWADDR    <= '0;
      ARADDR    <= '0;
      WDATA     <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      AWVALID   <= awvalid_d;
      WVALID    <= wvalid_d;
      BREADY    <= bready_d;
      ARVALID   <= arvalid_d;
      RREADY    <= rready_d;
      rsp_valid <= rsp_valid_d;
      AWADDR    <= awaddr_d;
      ARADDR    <= araddr_d;
      WDATA     <= wdata_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
    end
  end

endmodule

// File: tb/tb_axi8_lite_master.sv
// Directed bench for axi8_lite_master against a small 2-register slave model
// (reg 0 read/write, reg 1 reads ~reg0 and rejects writes with SLVERR).
`timescale 1ns/1ps
module tb_axi8_lite_master;
  localparam int unsigned AW = 1;
  localparam int unsigned DW = 8;
`ifdef AXI8M_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 255;
`endif

  logic          clk, ARESETN;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WSTRB, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [1:0]    BRESP, RRESP;

  axi8_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model; mode 0: AW then W, 1: W then AW, 2: AW and W together, 3: ARREADY never
  int         mode = 0;
  logic       aw_got, w_got;
  logic [7:0] reg0;

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    case (mode)
      1: begin WREADY = !w_got; AWREADY = w_got && !aw_got; end
      2: begin AWREADY = !aw_got; WREADY = !w_got; end
      default: begin AWREADY = !aw_got; WREADY = aw_got && !w_got; end
    endcase
    ARREADY = (mode != 3) && !RVALID;
  end

  always @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_got <= 1'b0; w_got <= 1'b0; reg0 <= 8'h00;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RDATA <= 8'h00; RRESP <= 2'b00;
    end else begin
      if (AWVALID && AWREADY) aw_got <= 1'b1;
      if (WVALID && WREADY)   w_got  <= 1'b1;
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY)) && !BVALID) begin
        BVALID <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
        if (AWADDR == 1'b0) begin reg0 <= WDATA; BRESP <= 2'b00; end
        else BRESP <= 2'b10;
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1; RRESP <= 2'b00;
        RDATA  <= ARADDR[0] ? ~reg0 : reg0;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  // Handshake and response-edge counters
  int   aw_hs = 0, w_hs = 0, b_hs = 0, rsp_rises = 0;
  logic rsp_prev = 1'b0;
  always @(posedge clk) begin
    if (ARESETN) begin
      if (AWVALID && AWREADY) aw_hs++;
      if (WVALID && WREADY)   w_hs++;
      if (BVALID && BREADY)   b_hs++;
    end
  end
  always @(negedge clk) begin
    if (rsp_valid && !rsp_prev) rsp_rises++;
    rsp_prev = rsp_valid;
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
  endtask

  // Called right after issue(); lat counts cycles from the accept cycle to rsp_valid
  task automatic wait_rsp(output int lat, output logic [7:0] rd, output logic [1:0] rs);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 100) begin lat++; @(negedge clk); end
    if (!rsp_valid) check_eq("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata; rs = rsp_resp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [7:0] d,
                     output int lat, output logic [7:0] rd, output logic [1:0] rs);
    issue(w, a, d);
    wait_rsp(lat, rd, rs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, n, bad, stray;
    logic [7:0] rd, held;
    logic [1:0] rs;

    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_valid_ready", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}), 32'd0);
    check_eq("rst_payload", 32'({AWADDR, ARADDR, WDATA, rsp_rdata, rsp_resp}), 32'd0);
    ARESETN = 1'b1;
    @(negedge clk);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    txn(1'b0, 1'b0, 8'h00, lat, rd, rs);
    check_eq("rd_after_rst_data", 32'(rd), 32'h00);
    check_eq("rd_latency", 32'(lat), 32'd3);

    issue(1'b1, 1'b0, 8'h5A);
    check_eq("wr_aw_w_wstrb", 32'({AWVALID, WVALID, WSTRB}), 32'b111);
    wait_rsp(lat, rd, rs);
    check_eq("wr_latency", 32'(lat), 32'd4);
    check_eq("wr_resp", 32'({rd, rs}), 32'h000);

    txn(1'b0, 1'b1, 8'h00, lat, rd, rs);
    check_eq("rd_addr1", 32'({rd, rs}), 32'({8'hA5, 2'b00}));
    txn(1'b0, 1'b0, 8'h00, lat, rd, rs);
    check_eq("rd_addr0", 32'({rd, rs}), 32'({8'h5A, 2'b00}));

    txn(1'b1, 1'b1, 8'hFF, lat, rd, rs);
    check_eq("wr_addr1_slverr", 32'(rs), 32'b10);
    txn(1'b0, 1'b0, 8'h00, lat, rd, rs);
    check_eq("rd_after_slverr", 32'(rd), 32'h5A);

    mode = 1;
    @(negedge clk); aw_hs = 0; w_hs = 0; b_hs = 0; rsp_rises = 0;
    txn(1'b1, 1'b0, 8'h33, lat, rd, rs);
    check_eq("w_first_counts", 32'({4'(aw_hs), 4'(w_hs), 4'(b_hs), 4'(rsp_rises)}), 32'h1111);
    check_eq("w_first_latency", 32'(lat), 32'd4);

    mode = 2;
    @(negedge clk); aw_hs = 0; w_hs = 0; b_hs = 0; rsp_rises = 0;
    txn(1'b1, 1'b0, 8'hC4, lat, rd, rs);
    check_eq("same_cycle_counts", 32'({4'(aw_hs), 4'(w_hs), 4'(b_hs), 4'(rsp_rises)}), 32'h1111);
    check_eq("same_cycle_latency", 32'(lat), 32'd3);

    mode = 0;
    txn(1'b0, 1'b1, 8'h00, lat, rd, rs);
    check_eq("rd_after_reorder", 32'(rd), 32'h3B);

    // Consumer stall with a stray command pulse
    issue(1'b0, 1'b0, 8'h00);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin n++; @(negedge clk); end
    held = rsp_rdata; bad = 0; stray = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i == 4); cmd_write = 1'b1;
      if (!rsp_valid || rsp_rdata != held || cmd_ready) bad++;
      if (AWVALID || ARVALID) stray++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check_eq("stall_stable", 32'(bad), 32'd0);
    check_eq("stall_data", 32'(held), 32'hC4);
    check_eq("stall_no_new_cmd", 32'(stray), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("stall_release", 32'({rsp_valid, cmd_ready}), 32'b01);

    // Reset while ARVALID is pending
    mode = 3;
    issue(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    check_eq("arvalid_pending", 32'(ARVALID), 32'd1);
    #2 ARESETN = 1'b0;
    #1 check_eq("arvalid_async_rst", 32'({ARVALID, rsp_valid, cmd_ready}), 32'd0);
    @(negedge clk); ARESETN = 1'b1; mode = 0;
    txn(1'b0, 1'b0, 8'h00, lat, rd, rs);
    check_eq("rd_after_midrst", 32'({rd, rs}), 32'h000);
    check_eq("rd_after_midrst_lat", 32'(lat), 32'd3);

`ifdef AXI8M_TIMEOUT_EN
    mode = 3;
    issue(1'b0, 1'b0, 8'h00);
    n = 0;
    @(negedge clk);
    while (ARVALID && n < 100) begin n++; @(negedge clk); end
    check_eq("tmo_arvalid_cycles", 32'(n), 32'd16);
    check_eq("tmo_rsp", 32'({rsp_valid, rsp_rdata, rsp_resp}), 32'({1'b1, 8'h00, 2'b11}));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    mode = 0;
    txn(1'b0, 1'b1, 8'h00, lat, rd, rs);
    check_eq("tmo_recover", 32'({rd, rs}), 32'({8'hFF, 2'b00}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi8_lite_master.md
Name: axi8_lite_master

Overview:
- Single-outstanding AXI4-Lite 8-bit master. Converts a simple command/response interface into AW/W/B or AR/R transactions.
- Drives the on-chip 2-register AXI-Lite slave; sits directly upstream of it, between that slave and the command source (pin decoder or sequencer).
- Only one transaction in flight; the result is held until the consumer accepts it.

Parameters:
ADDR_WIDTH, 1, width of cmd_addr/AWADDR/ARADDR
DATA_WIDTH, 8, data width (must be 8; WSTRB is 1 bit)
TIMEOUT_CYCLES, 255, slave-wait limit in cycles (used only with AXI8M_TIMEOUT_EN); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  master idle, command accepted on valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout
AWADDR  out  ADDR_WIDTH  write address
AWVALID  out  1
AWREADY  in  1
WDATA  out  DATA_WIDTH
WSTRB  out  1  always 1 during W
WVALID  out  1
WREADY  in  1
BVALID  in  1
BREADY  out  1
BRESP  in  2
ARADDR  out  ADDR_WIDTH
ARVALID  out  1
ARREADY  in  1
RVALID  in  1
RREADY  out  1
RDATA  in  DATA_WIDTH
RRESP  in  2

Behaviour:
- Reset (async, ARESETN low):
  - All VALID/READY outputs 0; rsp_valid 0.
  - AWADDR, ARADDR, WDATA, rsp_rdata, rsp_resp all 0.
  - State IDLE.
- All AXI and rsp outputs come from registers; no combinational READY->VALID path.
- States:
  - IDLE: cmd_ready=1. Command accepted on cmd_valid&cmd_ready. Address and data are latched.
    - Write -> WR_AW_W; AWVALID=WVALID=1 from the next cycle.
    - Read -> RD_AR; ARVALID=1 from the next cycle.
  - WR_AW_W: AW and W tracked independently.
    - AWVALID drops the cycle after AWVALID&AWREADY; WVALID drops the cycle after WVALID&WREADY.
    - Either order and same-cycle completion are legal. The downstream slave accepts AW before W, so W waits at least one cycle.
    - Both done -> WR_B with BREADY=1.
  - WR_B: on BVALID&BREADY, rsp_resp<=BRESP, rsp_rdata<=0, BREADY<=0 -> RSP.
  - RD_AR: on ARVALID&ARREADY, ARVALID<=0, RREADY<=1 -> RD_R.
  - RD_R: on RVALID&RREADY, rsp_rdata<=RDATA, rsp_resp<=RRESP, RREADY<=0 -> RSP.
  - RSP: rsp_valid=1, rsp_rdata/rsp_resp stable. On rsp_ready -> IDLE. cmd_ready returns the cycle after the handshake; no command accepted in the same cycle.
- VALID outputs, once high, stay high with stable payload until their handshake. Exception: timeout.
- Minimum latency against a zero-wait slave:
  - Read: cmd accept -> rsp_valid = 3 cycles.
  - Write: cmd accept -> rsp_valid = 4 cycles (AW, W, B serialized by the slave).
- cmd_write/cmd_addr/cmd_wdata are ignored outside the accept cycle.
- ARESETN asserted mid-transaction: immediate return to reset values. Slave shares the reset, so no dangling handshake.

Optional Feature:
- AXI8M_TIMEOUT_EN defined:
  - Counter clears on entry to WR_AW_W, WR_B, RD_AR and RD_R, and increments each cycle spent in them.
  - On reaching TIMEOUT_CYCLES: all VALID/READY outputs drop the next cycle, rsp_resp=2'b11, rsp_rdata=0 -> RSP. This is a deliberate recovery exception to the AXI VALID-stability rule.
  - A handshake in the expiry cycle wins; no timeout.
- Not defined: no counter; the master waits indefinitely; rsp_resp never 2'b11 unless the slave returns it.

Test Plan:
- Integration with the downstream slave: write addr 0 data 8'h5A, then read addr 1 -> rsp_rdata=8'hA5, rsp_resp=2'b00 both; write response 4 cycles after cmd accept.
- Integration: read addr 0 after the above -> rsp_rdata=8'h5A. Read after reset -> 8'h00.
- BFM slave asserts WREADY before AWREADY, then both in the same cycle on a second write -> each VALID drops exactly once, one B accepted, rsp_valid once per write.
- rsp_ready held low 10 cycles after a read -> rsp_valid and rsp_rdata stable, cmd_ready=0, a cmd_valid pulse ignored; rsp_ready=1 -> IDLE next cycle.
- ARESETN pulsed low while ARVALID=1 -> ARVALID=0 asynchronously, next command proceeds normally.
- AXI8M_TIMEOUT_EN, TIMEOUT_CYCLES=16, BFM never asserts ARREADY -> ARVALID drops after 16 cycles, rsp_resp=2'b11, rsp_rdata=8'h00.
